// File: rtl/panel_pkg.sv
// Shared types and constants for the panel scan sequencer and its shift timer.
package panel_pkg;

  localparam int PWM_BITS  = 8;
  localparam int PWM_STEPS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_BLOAD,
    ST_BSHIFT,
    ST_BLATCH
  } state_t;

  // Driver outputs stay blanked while idle and for the whole brightness reload.
  function automatic logic is_blank_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_BLOAD) || (s == ST_BSHIFT) || (s == ST_BLATCH);
  endfunction

endpackage

// File: rtl/panel_shift_timer.sv
// Serial-bit timer: NUM_BITS bits of SHIFT_DIV clocks each, started by a one-cycle pulse.
module panel_shift_timer #(
  parameter int NUM_BITS  = 16,
  parameter int SHIFT_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic shift,
  output logic sclk,
  output logic done
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SHIFT_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             shift_q, shift_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    active_d  = active_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (start) begin
      active_d  = 1'b1;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (active_q) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        if (bit_cnt_q == BIT_LAST) begin
          active_d  = 1'b0;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
    // Outputs are decoded from the next counter values so they leave a flop.
    shift_d = active_d && (div_cnt_d == DIV_LAST);
    sclk_d  = active_d && (div_cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
    end
  end

  assign shift = shift_q;
  assign sclk  = sclk_q;
  assign done  = active_q && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);

endmodule

// File: rtl/panel_scan_controller.sv
// PWM-slot sequencer for one panel: load, shift NUM_BITS bits, latch, with
// brightness reloads inserted just before the pwm_time=0 step.
module panel_scan_controller
  import panel_pkg::*;
#(
  parameter int NUM_BITS     = 16,
  parameter int SHIFT_DIV    = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                brightness_req,
  output logic [PWM_BITS-1:0] pwm_time,
  output logic                load_led_vals,
  output logic                load_brightness,
  output logic                shift,
  output logic                panel_sclk,
  output logic                panel_latch,
  output logic                panel_blank,
  output logic                frame_start,
  output logic                busy
);

  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(PWM_STEPS - 1);

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_time_q, pwm_time_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                pending_q, pending_d;
  logic                load_led_vals_q, load_led_vals_d;
  logic                load_brightness_q, load_brightness_d;
  logic                panel_latch_q, panel_latch_d;
  logic                panel_blank_q, panel_blank_d;
  logic                frame_start_q, frame_start_d;
  logic                busy_q, busy_d;

  logic timer_start;
  logic timer_done;
  logic timer_shift;
  logic timer_sclk;
  logic lat_last;

  assign timer_start = (state_q == ST_LOAD) || (state_q == ST_BLOAD);
  assign lat_last    = (lat_cnt_q == LAT_LAST);

  panel_shift_timer #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_DIV (SHIFT_DIV)
  ) u_shift_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .shift   (timer_shift),
    .sclk    (timer_sclk),
    .done    (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    pwm_time_d = pwm_time_q;
    lat_cnt_d  = lat_cnt_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = pending_q ? ST_BLOAD : ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (timer_done) state_d = ST_LATCH;
      ST_LATCH: begin
        if (lat_last) begin
          lat_cnt_d  = '0;
          pwm_time_d = pwm_time_q + 1'b1;
          if ((pwm_time_q == PWM_LAST) && pending_q && enable) state_d = ST_BLOAD;
          else if (enable)                                     state_d = ST_LOAD;
          else                                                 state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ST_BLOAD:  state_d = ST_BSHIFT;
      ST_BSHIFT: if (timer_done) state_d = ST_BLATCH;
      ST_BLATCH: begin
        if (lat_last) begin
          lat_cnt_d = '0;
          state_d   = ST_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    // A request landing in the BLOAD cycle survives the clear.
    pending_d = brightness_req || (pending_q && (state_q != ST_BLOAD));

    load_led_vals_d   = (state_d == ST_LOAD);
    load_brightness_d = (state_d == ST_BLOAD);
    panel_latch_d     = (state_d == ST_LATCH) || (state_d == ST_BLATCH);
    panel_blank_d     = is_blank_state(state_d);
    frame_start_d     = (state_d == ST_LOAD) && (pwm_time_d == '0);
    busy_d            = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      pwm_time_q        <= '0;
      lat_cnt_q         <= '0;
      pending_q         <= 1'b0;
      load_led_vals_q   <= 1'b0;
      load_brightness_q <= 1'b0;
      panel_latch_q     <= 1'b0;
      panel_blank_q     <= 1'b1;
      frame_start_q     <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      pwm_time_q        <= pwm_time_d;
      lat_cnt_q         <= lat_cnt_d;
      pending_q         <= pending_d;
      load_led_vals_q   <= load_led_vals_d;
      load_brightness_q <= load_brightness_d;
      panel_latch_q     <= panel_latch_d;
      panel_blank_q     <= panel_blank_d;
      frame_start_q     <= frame_start_d;
      busy_q            <= busy_d;
    end
  end

  assign pwm_time        = pwm_time_q;
  assign load_led_vals   = load_led_vals_q;
  assign load_brightness = load_brightness_q;
  assign shift           = timer_shift;
  assign panel_sclk      = timer_sclk;
  assign panel_latch     = panel_latch_q;
  assign panel_blank     = panel_blank_q;
  assign frame_start     = frame_start_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_panel_scan_controller.sv
// Scoreboard bench for panel_scan_controller: expected PWM steps are queued by
// each scenario and checked by a monitor as the controller starts and ends them.
module tb_panel_scan_controller;

  localparam int NB    = 16;
  localparam int SD    = 2;
  localparam int LC    = 2;
  localparam int STEP  = 1 + NB * SD + LC;
  localparam int FRAME = 256 * STEP;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       brightness_req;
  logic [7:0] pwm_time;
  logic       load_led_vals;
  logic       load_brightness;
  logic       shift;
  logic       panel_sclk;
  logic       panel_latch;
  logic       panel_blank;
  logic       frame_start;
  logic       busy;

  always #5 clk = ~clk;

  panel_scan_controller #(
    .NUM_BITS     (NB),
    .SHIFT_DIV    (SD),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .brightness_req  (brightness_req),
    .pwm_time        (pwm_time),
    .load_led_vals   (load_led_vals),
    .load_brightness (load_brightness),
    .shift           (shift),
    .panel_sclk      (panel_sclk),
    .panel_latch     (panel_latch),
    .panel_blank     (panel_blank),
    .frame_start     (frame_start),
    .busy            (busy)
  );

  typedef struct {
    logic       bright;
    logic [7:0] pwm;
    logic [7:0] pwm_after;
    int         gap;
  } step_t;

  step_t exp_q[$];
  step_t cur;
  int    fs_cyc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    in_step = 0;
  bit    start_now = 0;
  int    last_start = 0;
  int    n_shift, n_sclk, n_latch, n_bad_blank, n_bad_fs;
  logic  latch_prev = 1'b0;
  logic  sclk_prev  = 1'b0;

  // Monitor: pops one expected step per load strobe, audits it when the latch ends.
  always @(negedge clk) begin
    cyc++;
    start_now = 0;
    if (!reset_n) begin
      in_step    = 0;
      latch_prev = 1'b0;
      sclk_prev  = 1'b0;
    end else begin
      if (in_step && latch_prev && !panel_latch) begin
        in_step = 0;
        checks++;
        if (n_shift !== NB) begin
          errors++; $display("FAIL step_shifts pwm %0d got %0d want %0d", cur.pwm, n_shift, NB);
        end
        checks++;
        if (n_sclk !== NB) begin
          errors++; $display("FAIL step_sclk_pulses pwm %0d got %0d want %0d", cur.pwm, n_sclk, NB);
        end
        checks++;
        if (n_latch !== LC) begin
          errors++; $display("FAIL step_latch_width pwm %0d got %0d want %0d", cur.pwm, n_latch, LC);
        end
        checks++;
        if (n_bad_blank !== 0) begin
          errors++; $display("FAIL step_blank pwm %0d got %0d wrong cycles want 0", cur.pwm, n_bad_blank);
        end
        checks++;
        if (n_bad_fs !== 0) begin
          errors++; $display("FAIL stray_frame_start pwm %0d got %0d want 0", cur.pwm, n_bad_fs);
        end
        checks++;
        if (pwm_time !== cur.pwm_after) begin
          errors++; $display("FAIL pwm_after_step got %0d want %0d", pwm_time, cur.pwm_after);
        end
      end
      if (load_led_vals || load_brightness) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_step got pwm %0d bright %0b want none", pwm_time, load_brightness);
        end else begin
          cur = exp_q.pop_front();
          start_now = 1;
          if ({load_led_vals, load_brightness, pwm_time} !== {~cur.bright, cur.bright, cur.pwm}) begin
            errors++;
            $display("FAIL step_start got led %0b bright %0b pwm %0d want led %0b bright %0b pwm %0d",
                     load_led_vals, load_brightness, pwm_time, ~cur.bright, cur.bright, cur.pwm);
          end
          checks++;
          if (frame_start !== (cur.pwm == 8'd0 && !cur.bright)) begin
            errors++; $display("FAIL frame_start got %0b want %0b", frame_start, (cur.pwm == 8'd0 && !cur.bright));
          end
          if (cur.gap != 0) begin
            checks++;
            if (cyc - last_start != cur.gap) begin
              errors++; $display("FAIL step_period pwm %0d got %0d want %0d", cur.pwm, cyc - last_start, cur.gap);
            end
          end
          last_start  = cyc;
          in_step     = 1;
          n_shift     = 0;
          n_sclk      = 0;
          n_latch     = 0;
          n_bad_blank = 0;
          n_bad_fs    = 0;
        end
      end
      if (in_step) begin
        if (shift) n_shift++;
        if (panel_sclk && !sclk_prev) n_sclk++;
        if (panel_latch) n_latch++;
        if (panel_blank !== cur.bright) n_bad_blank++;
        if (frame_start && !start_now) n_bad_fs++;
      end
      if (frame_start) fs_cyc_q.push_back(cyc);
      latch_prev = panel_latch;
      sclk_prev  = panel_sclk;
    end
  end

  task automatic push_step(input bit b, input int p, input int gap);
    step_t s;
    s.bright    = b;
    s.pwm       = 8'(p);
    s.pwm_after = b ? 8'(p) : 8'((p + 1) % 256);
    s.gap       = gap;
    exp_q.push_back(s);
  endtask

  task automatic push_run(input int first, input int last, input int first_gap);
    for (int p = first; p <= last; p++) push_step(1'b0, p, (p == first) ? first_gap : STEP);
  endtask

  task automatic wait_drain(input int budget, input string what);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_timeout got %0d steps pending want 0", what, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_step_end(input int budget, input string what);
    int n = 0;
    while (in_step && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (in_step) begin
      errors++; $display("FAIL %s_step_end_timeout got busy %0b want step finished", what, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; brightness_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pwm_time !== 8'd0) begin
      errors++; $display("FAIL reset_pwm got %0d want 0", pwm_time);
    end
    checks++;
    if ({load_led_vals, load_brightness, shift, panel_sclk, panel_latch, frame_start, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000000",
                         {load_led_vals, load_brightness, shift, panel_sclk, panel_latch, frame_start, busy});
    end
    checks++;
    if (panel_blank !== 1'b1) begin
      errors++; $display("FAIL reset_blank got %0b want 1", panel_blank);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, panel_blank, load_led_vals} !== 3'b010) begin
      errors++; $display("FAIL idle_after_reset got %b want 010", {busy, panel_blank, load_led_vals});
    end
  endtask

  task automatic test_scan_and_pause();
    @(posedge clk); #1 enable = 1'b1;
    push_run(0, 5, 0);
    @(negedge clk);
    checks++;
    if ({load_led_vals, busy} !== 2'b00) begin
      errors++; $display("FAIL enable_latency_early got %b want 00", {load_led_vals, busy});
    end
    @(negedge clk);
    checks++;
    if ({load_led_vals, busy, panel_blank} !== 3'b110) begin
      errors++; $display("FAIL enable_latency got %b want 110", {load_led_vals, busy, panel_blank});
    end
    wait_drain(7 * STEP, "scan");
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_time !== 8'd5) begin
      errors++; $display("FAIL pwm_mid_step got %0d want 5", pwm_time);
    end
    enable = 1'b0;
    wait_step_end(STEP + 5, "pause");
    checks++;
    if ({busy, panel_blank, pwm_time} !== {1'b0, 1'b1, 8'd6}) begin
      errors++; $display("FAIL pause_idle got busy %0b blank %0b pwm %0d want busy 0 blank 1 pwm 6",
                         busy, panel_blank, pwm_time);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, load_led_vals, pwm_time} !== {1'b0, 1'b0, 8'd6}) begin
      errors++; $display("FAIL pause_hold got busy %0b load %0b pwm %0d want 0 0 6", busy, load_led_vals, pwm_time);
    end
  endtask

  task automatic test_resume_and_wrap();
    fs_cyc_q.delete();
    @(posedge clk); #1 enable = 1'b1;
    push_run(6, 255, 0);
    push_run(0, 255, STEP);
    push_step(1'b0, 0, STEP);
    wait_drain(520 * STEP, "wrap");
    enable = 1'b0;
    wait_step_end(STEP + 5, "wrap");
    checks++;
    if (fs_cyc_q.size() !== 2) begin
      errors++; $display("FAIL frame_start_count got %0d want 2", fs_cyc_q.size());
    end else begin
      checks++;
      if (fs_cyc_q[1] - fs_cyc_q[0] !== FRAME) begin
        errors++; $display("FAIL frame_period got %0d want %0d", fs_cyc_q[1] - fs_cyc_q[0], FRAME);
      end
    end
    checks++;
    if ({busy, pwm_time} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL wrap_idle got busy %0b pwm %0d want 0 1", busy, pwm_time);
    end
  endtask

  task automatic test_brightness_reload();
    int n = 0;
    @(posedge clk); #1 enable = 1'b1;
    push_run(1, 255, 0);
    push_step(1'b1, 0, STEP);
    push_step(1'b0, 0, STEP);
    while (pwm_time !== 8'd10 && n < 12 * STEP) begin
      @(negedge clk); n++;
    end
    checks++;
    if (pwm_time !== 8'd10) begin
      errors++; $display("FAIL reach_pwm10 got %0d want 10", pwm_time);
    end
    @(posedge clk); #1 brightness_req = 1'b1;
    @(posedge clk); #1 brightness_req = 1'b0;
    wait_drain(260 * STEP, "bright");
    enable = 1'b0;
    wait_step_end(STEP + 5, "bright");
    checks++;
    if ({busy, pwm_time} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL bright_idle got busy %0b pwm %0d want 0 1", busy, pwm_time);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(posedge clk); #1 enable = 1'b1;
    push_run(1, 255, 0);
    push_step(1'b1, 0, STEP);
    push_run(0, 255, STEP);
    push_step(1'b1, 0, STEP);
    push_step(1'b0, 0, STEP);
    @(posedge clk); #1 brightness_req = 1'b1;
    @(posedge clk); #1 brightness_req = 1'b0;
    while (load_brightness !== 1'b1 && n < 260 * STEP) begin
      @(negedge clk); n++;
    end
    checks++;
    if (load_brightness !== 1'b1) begin
      errors++; $display("FAIL first_bload got %0b want 1", load_brightness);
    end
    brightness_req = 1'b1;
    @(posedge clk); #1 brightness_req = 1'b0;
    wait_drain(520 * STEP, "b2b");
    enable = 1'b0;
    wait_step_end(STEP + 5, "b2b");
    checks++;
    if ({busy, pwm_time} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL b2b_idle got busy %0b pwm %0d want 0 1", busy, pwm_time);
    end
  endtask

  task automatic test_reset_in_latch();
    int n = 0;
    int latch_seen = 0;
    @(posedge clk); #1 enable = 1'b1;
    push_step(1'b0, 1, 0);
    while (panel_latch !== 1'b1 && n < 2 * STEP) begin
      @(negedge clk); n++;
    end
    checks++;
    if (panel_latch !== 1'b1) begin
      errors++; $display("FAIL reach_latch got %0b want 1", panel_latch);
    end
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    checks++;
    if ({panel_latch, busy, load_led_vals, shift, panel_sclk, panel_blank, pwm_time} !==
        {6'b000001, 8'd0}) begin
      errors++; $display("FAIL async_reset got latch %0b busy %0b blank %0b pwm %0d want 0 0 1 0",
                         panel_latch, busy, panel_blank, pwm_time);
    end
    repeat (4) begin
      @(negedge clk);
      if (panel_latch) latch_seen++;
    end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (panel_latch) latch_seen++;
    end
    checks++;
    if (latch_seen !== 0) begin
      errors++; $display("FAIL latch_after_reset got %0d cycles want 0", latch_seen);
    end
    checks++;
    if ({busy, pwm_time, exp_q.size() == 0} !== {1'b0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL post_reset_idle got busy %0b pwm %0d pending %0d want 0 0 0",
                         busy, pwm_time, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_scan_and_pause();
    test_resume_and_wrap();
    test_brightness_reload();
    test_back_to_back();
    test_reset_in_latch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
